// File: rtl/debug_dump_sequencer.sv
// Debug dump sequencer: after a debug request, reads the last PC, every register-bank entry
// and every data-memory word, and sends each 32-bit value LSB-first as four UART bytes.
module debug_dump_sequencer #(
   parameter int unsigned DWORD    = 32,
   parameter int unsigned BYTE     = 8,
   parameter int unsigned RB_ADDR  = 5,
   parameter int unsigned MEM_ADDR = 5
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [DWORD-1:0]    i_pc_value,
   input  logic [DWORD-1:0]    i_rb_data,
   input  logic [DWORD-1:0]    i_mem_data,
   input  logic                i_tx_done,
   output logic [RB_ADDR-1:0]  o_rb_addr,
   output logic                o_rb_enable,
   output logic                o_rb_read_enable,
   output logic [MEM_ADDR-1:0] o_mem_addr,
   output logic                o_mem_enable,
   output logic                o_mem_read_enable,
   output logic                o_mem_debug_unit,
   output logic [BYTE-1:0]     o_tx_data,
   output logic                o_tx_start,
   output logic                o_busy,
   output logic                o_done
);

   localparam int unsigned NumBytes = DWORD / BYTE;
   localparam int unsigned ByteCntW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
   // One spare bit so the last-index compare never sees a wrapped counter.
   localparam int unsigned IdxW     = ((RB_ADDR > MEM_ADDR) ? RB_ADDR : MEM_ADDR) + 1;

   localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(NumBytes - 1);
   localparam logic [IdxW-1:0]     RbLast   = IdxW'((1 << RB_ADDR) - 1);
   localparam logic [IdxW-1:0]     MemLast  = IdxW'((1 << MEM_ADDR) - 1);

   typedef enum logic [2:0] {
      StIdle, StLoad, StCapture, StSend, StWaitTx, StNext, StDone
   } state_e;

   typedef enum logic [1:0] {
      PhPc, PhRb, PhMem
   } phase_e;

   state_e                r_state, w_state_next;
   phase_e                r_phase, w_phase_next;
   logic [IdxW-1:0]       r_index, w_index_next;
   logic [ByteCntW-1:0]   r_byte_cnt, w_byte_cnt_next;
   logic [DWORD-1:0]      r_shift, w_shift_next;
   logic                  w_last_idx;
   logic                  w_load_cap;

   assign w_last_idx = (r_phase == PhPc) ||
                       ((r_phase == PhRb) && (r_index == RbLast)) ||
                       ((r_phase == PhMem) && (r_index == MemLast));
   assign w_load_cap = (r_state == StLoad) || (r_state == StCapture);

   // State and datapath registers; reset abandons any dump in progress.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= StIdle;
         r_phase    <= PhPc;
         r_index    <= '0;
         r_byte_cnt <= '0;
         r_shift    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_phase    <= w_phase_next;
         r_index    <= w_index_next;
         r_byte_cnt <= w_byte_cnt_next;
         r_shift    <= w_shift_next;
      end
   end

   // Next-state logic: walk PC, register bank, then data memory, four bytes per word.
   always_comb begin
      w_state_next    = r_state;
      w_phase_next    = r_phase;
      w_index_next    = r_index;
      w_byte_cnt_next = r_byte_cnt;
      w_shift_next    = r_shift;
      case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_next = StLoad;
               w_phase_next = PhPc;
               w_index_next = '0;
            end
         end
         StLoad:    w_state_next = StCapture;
         StCapture: begin
            unique case (r_phase)
               PhRb:    w_shift_next = i_rb_data;
               PhMem:   w_shift_next = i_mem_data;
               default: w_shift_next = i_pc_value;
            endcase
            w_byte_cnt_next = '0;
            w_state_next    = StSend;
         end
         StSend:    w_state_next = StWaitTx;
         StWaitTx: begin
            if (i_tx_done) begin
               w_shift_next    = r_shift >> BYTE;
               w_byte_cnt_next = r_byte_cnt + 1'b1;
               w_state_next    = (r_byte_cnt == LastByte) ? StNext : StSend;
            end
         end
         StNext: begin
            if (w_last_idx) begin
               w_index_next = '0;
               unique case (r_phase)
                  PhPc: begin
                     w_phase_next = PhRb;
                     w_state_next = StLoad;
                  end
                  PhRb: begin
                     w_phase_next = PhMem;
                     w_state_next = StLoad;
                  end
                  default: w_state_next = StDone;
               endcase
            end else begin
               w_index_next = r_index + 1'b1;
               w_state_next = StLoad;
            end
         end
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs decoded from state; read ports are driven only across LOAD and CAPTURE.
   always_comb begin
      o_rb_addr         = '0;
      o_rb_enable       = 1'b0;
      o_rb_read_enable  = 1'b0;
      o_mem_addr        = '0;
      o_mem_enable      = 1'b0;
      o_mem_read_enable = 1'b0;
      o_tx_data         = '0;
      if (w_load_cap && (r_phase == PhRb)) begin
         o_rb_addr        = r_index[RB_ADDR-1:0];
         o_rb_enable      = 1'b1;
         o_rb_read_enable = 1'b1;
      end
      if (w_load_cap && (r_phase == PhMem)) begin
         o_mem_addr        = r_index[MEM_ADDR-1:0];
         o_mem_enable      = 1'b1;
         o_mem_read_enable = 1'b1;
      end
      if ((r_state == StSend) || (r_state == StWaitTx)) begin
         o_tx_data = r_shift[BYTE-1:0];
      end
      o_mem_debug_unit = (r_phase == PhMem) && (r_state != StIdle) && (r_state != StDone);
      o_tx_start       = (r_state == StSend);
      o_busy           = (r_state != StIdle);
      o_done           = (r_state == StDone);
   end

endmodule
